// File: rtl/alu_shift_seq.sv
// alu_shift_seq: multi-cycle barrel-shifter replacement for the ALU.
// Shifts one bit per clock; result and a one-cycle done pulse are registered.
module alu_shift_seq #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             right,
  input  logic             Sign,
  output logic [WIDTH-1:0] S,
  output logic             busy,
  output logic             done
);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   data_q,  data_d;
  logic [SHW-1:0]     cnt_q,   cnt_d;
  logic               right_q, right_d;
  logic               sign_q,  sign_d;
  logic [WIDTH-1:0]   s_q,     s_d;
  logic               busy_q,  busy_d;
  logic               done_q,  done_d;

  // Shift amount is taken modulo WIDTH; the upper operand bits are don't-care.
  logic unused_a_hi;
  assign unused_a_hi = ^A[WIDTH-1:SHW];

  // State and datapath registers; reset aborts any operation in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      data_q  <= '0;
      cnt_q   <= '0;
      right_q <= 1'b0;
      sign_q  <= 1'b0;
      s_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
      right_q <= right_d;
      sign_q  <= sign_d;
      s_q     <= s_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Next-state: capture operands in IDLE, one shift step per cycle in SHIFT.
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    right_d = right_q;
    sign_d  = sign_q;
    s_d     = s_q;
    busy_d  = busy_q;
    done_d  = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          data_d  = B;
          cnt_d   = A[SHW-1:0];
          right_d = right;
          sign_d  = Sign;
          busy_d  = 1'b1;
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - SHW'(1);
          if (!right_q) begin
            data_d = {data_q[WIDTH-2:0], 1'b0};
          end else if (sign_q) begin
            // MSB stays put, so the original sign bit is replicated every step.
            data_d = {data_q[WIDTH-1], data_q[WIDTH-1:1]};
          end else begin
            data_d = {1'b0, data_q[WIDTH-1:1]};
          end
        end else begin
          s_d     = data_q;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  assign S    = s_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_alu_shift_seq.sv
// Self-checking bench for alu_shift_seq against an arithmetic shift model.
module tb_alu_shift_seq;

  localparam int unsigned W = 32;

  logic         clk;
  logic         reset;
  logic         start;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic         right;
  logic         Sign;
  logic [W-1:0] S;
  logic         busy;
  logic         done;

  int n_cmp;
  int n_err;

  alu_shift_seq #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .A     (A),
    .B     (B),
    .right (right),
    .Sign  (Sign),
    .S     (S),
    .busy  (busy),
    .done  (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: plain operator shift with amount taken mod W.
  function automatic logic [W-1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic r, input logic sg);
    int sh;
    logic signed [W-1:0] bs;
    sh = int'(a % W);
    bs = b;
    if (!r) return b << sh;
    if (sg) return W'(bs >>> sh);
    return b >> sh;
  endfunction

  function automatic int model_lat(input logic [W-1:0] a);
    return int'(a % W) + 1;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue one operation, scramble operands after acceptance, wait for done.
  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic r, input logic sg, input logic hold_start,
                       output logic [W-1:0] res, output int lat,
                       output int busy_cyc, output logic overlap);
    A = a; B = b; right = r; Sign = sg; start = 1'b1;
    step();
    start = hold_start;
    res = 'x; lat = 0; overlap = 1'b0;
    busy_cyc = busy ? 1 : 0;
    for (int i = 0; i < W + 8; i++) begin
      A = $urandom; B = $urandom; right = 1'($urandom); Sign = 1'($urandom);
      step();
      lat++;
      if (busy && done) overlap = 1'b1;
      if (done) begin
        res = S;
        break;
      end
      if (busy) busy_cyc++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; start = 1'b0; A = '0; B = '0; right = 1'b0; Sign = 1'b0;
    for (int i = 0; i < 6; i++) begin
      start = ~start; A = $urandom; B = $urandom;
      step();
      n_cmp++;
      if ({S, busy, done} !== {{W{1'b0}}, 2'b00}) begin
        n_err++;
        $display("FAIL reset_hold cyc%0d: S=%h busy=%b done=%b, want 0/0/0", i, S, busy, done);
      end
    end
    start = 1'b0;
    #3 reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      n_cmp++;
      if ({S, busy, done} !== {{W{1'b0}}, 2'b00}) begin
        n_err++;
        $display("FAIL reset_release_idle cyc%0d: S=%h busy=%b done=%b, want 0/0/0", i, S, busy, done);
      end
    end
  endtask

  task automatic test_left();
    logic [W-1:0] res; int lat; int bc; logic ov;
    for (int sg = 0; sg < 2; sg++) begin
      do_op(32'd4, 32'd24, 1'b0, 1'(sg), 1'b0, res, lat, bc, ov);
      n_cmp++;
      if (res !== 32'd384) begin
        n_err++; $display("FAIL left_result sign=%0d: got %0d, want 384", sg, res);
      end
      n_cmp++;
      if (lat != 5 || bc != 5 || ov) begin
        n_err++; $display("FAIL left_timing sign=%0d: lat=%0d busy=%0d ov=%b, want 5/5/0", sg, lat, bc, ov);
      end
      step();
      n_cmp++;
      if (done !== 1'b0 || S !== 32'd384) begin
        n_err++; $display("FAIL done_pulse_width: done=%b S=%0d, want 0/384", done, S);
      end
    end
  endtask

  task automatic test_right();
    logic [W-1:0] res; int lat; int bc; logic ov;
    do_op(32'd25, 32'hF8A432EB, 1'b1, 1'b0, 1'b0, res, lat, bc, ov);
    n_cmp++;
    if (res !== 32'h0000007C || lat != 26) begin
      n_err++; $display("FAIL right_logical: got %h lat %0d, want 0000007c lat 26", res, lat);
    end
    do_op(32'd25, 32'hF8A432EB, 1'b1, 1'b1, 1'b0, res, lat, bc, ov);
    n_cmp++;
    if (res !== 32'hFFFFFFFC || lat != 26) begin
      n_err++; $display("FAIL right_arith: got %h lat %0d, want fffffffc lat 26", res, lat);
    end
    do_op(32'd4, 32'd88888, 1'b1, 1'b0, 1'b0, res, lat, bc, ov);
    n_cmp++;
    if (res !== 32'd5555) begin
      n_err++; $display("FAIL right_small: got %0d, want 5555", res);
    end
  endtask

  task automatic test_zero_trunc();
    logic [W-1:0] res; int lat; int bc; logic ov; logic [W-1:0] b;
    do_op(32'd0, 32'd2644546165, 1'b1, 1'b0, 1'b0, res, lat, bc, ov);
    n_cmp++;
    if (res !== 32'd2644546165 || lat != 1 || bc != 1) begin
      n_err++; $display("FAIL zero_amount: got %0d lat %0d busy %0d, want 2644546165 lat 1 busy 1", res, lat, bc);
    end
    b = $urandom;
    do_op(32'd36, b, 1'b0, 1'b0, 1'b0, res, lat, bc, ov);
    n_cmp++;
    if (res !== (b << 4) || lat != 5) begin
      n_err++; $display("FAIL trunc_amount: got %h lat %0d, want %h lat 5", res, lat, b << 4);
    end
  endtask

  task automatic test_random();
    logic [W-1:0] res; int lat; int bc; logic ov;
    logic [W-1:0] a; logic [W-1:0] b; logic r; logic sg;
    for (int i = 0; i < 24; i++) begin
      a = $urandom; b = $urandom; r = 1'($urandom); sg = 1'($urandom);
      if (i < 4) b[W-1] = 1'b1;
      do_op(a, b, r, sg, 1'b0, res, lat, bc, ov);
      n_cmp++;
      if (res !== model(a, b, r, sg) || lat != model_lat(a) || bc != model_lat(a) || ov) begin
        n_err++;
        $display("FAIL random_%0d a=%h b=%h r=%b s=%b: got %h lat %0d busy %0d ov %b, want %h lat %0d",
                 i, a, b, r, sg, res, lat, bc, ov, model(a, b, r, sg), model_lat(a));
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] res; int lat; int bc; logic ov;
    // start held high throughout; operands scrambled every cycle
    do_op(32'd7, 32'h8000_1234, 1'b1, 1'b1, 1'b1, res, lat, bc, ov);
    n_cmp++;
    if (res !== model(32'd7, 32'h8000_1234, 1'b1, 1'b1) || lat != 8 || ov) begin
      n_err++; $display("FAIL start_while_busy: got %h lat %0d, want %h lat 8", res, lat,
                        model(32'd7, 32'h8000_1234, 1'b1, 1'b1));
    end
    // still in the done cycle: new request must be accepted on the next edge
    do_op(32'd2, 32'd9, 1'b0, 1'b0, 1'b0, res, lat, bc, ov);
    n_cmp++;
    if (res !== 32'd36 || lat != 3) begin
      n_err++; $display("FAIL back_to_back: got %0d lat %0d, want 36 lat 3", res, lat);
    end
  endtask

  task automatic test_abort();
    logic [W-1:0] res; int lat; int bc; logic ov; logic saw_done;
    A = 32'd20; B = 32'd4; right = 1'b0; Sign = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 9; i++) step();
    #2 reset = 1'b0;
    #1;
    n_cmp++;
    if ({S, busy, done} !== {{W{1'b0}}, 2'b00}) begin
      n_err++; $display("FAIL abort_async: S=%h busy=%b done=%b, want 0/0/0", S, busy, done);
    end
    saw_done = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      if (done) saw_done = 1'b1;
    end
    #3 reset = 1'b1;
    for (int i = 0; i < 25; i++) begin
      step();
      if (done || busy) saw_done = 1'b1;
    end
    n_cmp++;
    if (saw_done !== 1'b0 || S !== '0) begin
      n_err++; $display("FAIL abort_no_done: activity=%b S=%h, want 0/0", saw_done, S);
    end
    do_op(32'd1, 32'd25, 1'b1, 1'b0, 1'b0, res, lat, bc, ov);
    n_cmp++;
    if (res !== 32'd12 || lat != 2) begin
      n_err++; $display("FAIL after_abort: got %0d lat %0d, want 12 lat 2", res, lat);
    end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    test_reset();
    test_left();
    test_right();
    test_zero_trunc();
    test_random();
    test_back_to_back();
    test_abort();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
